// File: rtl/ecg_beat_synth_if.sv
// Sample-stream bundle for ecg_beat_synth.
// The master drives the run controls, the strobe and the beat configuration.
// The slave (the synthesizer) returns the sample, its valid and R-peak flags,
// the completed-beat count and the configuration error flag.
//   en        : run enable, looked at only on beat boundaries
//   sample_en : one output sample per strobe
//   rr_int    : beat period in samples
//   qrs_w     : QRS width in samples
//   d_out     : current ECG sample
//   d_valid   : one-cycle pulse, d_out updated
//   r_mark    : high with d_valid on the R-peak sample
//   beat_cnt  : completed-beat count
//   cfg_err   : last configuration check failed
interface ecg_beat_synth_if #(
  parameter int unsigned RR_W = 16
) ();
  logic            en;
  logic            sample_en;
  logic [RR_W-1:0] rr_int;
  logic [7:0]      qrs_w;
  logic [7:0]      d_out;
  logic            d_valid;
  logic            r_mark;
  logic [15:0]     beat_cnt;
  logic            cfg_err;

  modport master (
    output en, sample_en, rr_int, qrs_w,
    input  d_out, d_valid, r_mark, beat_cnt, cfg_err
  );

  modport slave (
    input  en, sample_en, rr_int, qrs_w,
    output d_out, d_valid, r_mark, beat_cnt, cfg_err
  );
endinterface

// File: rtl/ecg_beat_synth.sv
// Synthetic ECG sample source: piecewise-linear QRS complexes on a flat baseline.
// One sample is produced per sample_en strobe, registered (latency 1).
// A beat of rr_int samples is Q (L), R_UP (L), R_DN (L), S (qrs_w-3L), BASE (rest),
// with L = qrs_w >> 2. Config is checked and latched only at beat boundaries.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : ecg_beat_synth_if slave (controls/config in, sample stream out)
module ecg_beat_synth #(
  parameter logic [7:0]  BASELINE = 8'd64,
  parameter logic [7:0]  Q_STEP   = 8'd4,
  parameter logic [7:0]  R_STEP   = 8'd32,
  parameter logic [7:0]  S_STEP   = 8'd8,
  parameter int unsigned RR_W     = 16
) (
  input logic               clk,
  input logic               rst,
  ecg_beat_synth_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StBeat} state_e;

  state_e          state_q, state_d;
  logic [RR_W-1:0] idx_q, idx_d;    // index of the next sample within the beat
  logic [RR_W-1:0] rr_q, rr_d;
  logic [7:0]      qrs_q, qrs_d;
  logic [5:0]      l_q, l_d;
  logic [7:0]      d_out_q, d_out_d;
  logic            d_valid_q, d_valid_d;
  logic            r_mark_q, r_mark_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;
  logic            cfg_err_q, cfg_err_d;

  logic            cfg_ok;
  logic            start;
  logic [RR_W-1:0] cur_idx, cur_rr, cur_qrs, l_ext;
  logic [5:0]      cur_l;
  logic [7:0]      s_val;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b};
    return t[8] ? 8'd0 : t[7:0];
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[8] ? 8'hff : t[7:0];
  endfunction

  assign cfg_ok = (bus.qrs_w >= 8'd4) && (RR_W'(bus.qrs_w) < bus.rr_int);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    qrs_d      = qrs_q;
    l_d        = l_q;
    d_out_d    = d_out_q;
    d_valid_d  = 1'b0;
    r_mark_d   = 1'b0;
    beat_cnt_d = beat_cnt_q;
    cfg_err_d  = cfg_err_q;
    start      = 1'b0;
    s_val      = 8'd0;

    if (bus.sample_en && (state_q == StIdle) && bus.en) begin
      if (cfg_ok) begin
        start     = 1'b1;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // A starting beat uses the live config, and this very sample is index 0.
    cur_idx = start ? '0 : idx_q;
    cur_rr  = start ? bus.rr_int : rr_q;
    cur_qrs = start ? RR_W'(bus.qrs_w) : RR_W'(qrs_q);
    cur_l   = start ? bus.qrs_w[7:2] : l_q;
    l_ext   = RR_W'(cur_l);

    if (bus.sample_en) begin
      d_valid_d = 1'b1;
      if ((state_q == StIdle) && !start) begin
        d_out_d = BASELINE;
      end else begin
        if (start) begin
          rr_d  = bus.rr_int;
          qrs_d = bus.qrs_w;
          l_d   = bus.qrs_w[7:2];
        end

        if (cur_idx < l_ext) begin
          d_out_d = sat_sub(d_out_q, Q_STEP);
        end else if (cur_idx < (l_ext << 1)) begin
          d_out_d  = sat_add(d_out_q, R_STEP);
          r_mark_d = (cur_idx == (l_ext << 1) - RR_W'(1));
        end else if (cur_idx < (l_ext + (l_ext << 1))) begin
          d_out_d = sat_sub(d_out_q, R_STEP);
        end else if (cur_idx < cur_qrs) begin
          s_val   = sat_add(d_out_q, S_STEP);
          d_out_d = (s_val > BASELINE) ? BASELINE : s_val;
          // The S tail always lands exactly on the baseline.
          if (cur_idx == cur_qrs - RR_W'(1)) d_out_d = BASELINE;
        end else begin
          d_out_d = BASELINE;
        end

        if (cur_idx == cur_rr - RR_W'(1)) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          idx_d      = '0;
          if (bus.en && cfg_ok) begin
            rr_d      = bus.rr_int;
            qrs_d     = bus.qrs_w;
            l_d       = bus.qrs_w[7:2];
            cfg_err_d = 1'b0;
            state_d   = StBeat;
          end else begin
            if (bus.en) cfg_err_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          idx_d   = cur_idx + RR_W'(1);
          state_d = StBeat;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rr_q       <= '0;
      qrs_q      <= '0;
      l_q        <= '0;
      d_out_q    <= BASELINE;
      d_valid_q  <= 1'b0;
      r_mark_q   <= 1'b0;
      beat_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      qrs_q      <= qrs_d;
      l_q        <= l_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
      r_mark_q   <= r_mark_d;
      beat_cnt_q <= beat_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.r_mark   = r_mark_q;
  assign bus.beat_cnt = beat_cnt_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule
